// File: rtl/dmem_ctrl_pkg.sv
// Shared types and the store lane-mask helper for the dmem_ctrl data-memory controller.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte lanes touched by an access of the given size at the given lane offset.
  function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lane;
      SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH_WORDS x 32 storage with per-byte write enables and a combinational read port.
module dmem_bank #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Byte/half/word load-store controller in front of dmem_bank with READ_LAT-cycle load latency.
// Define DMEM_CTRL_CHECK_EN to flag misaligned, reserved-size and out-of-range accesses.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [31:0] hold_word_q;
  mem_size_t   hold_size_q;
  logic [1:0]  hold_lane_q;
  logic        hold_uns_q;

  mem_size_t   req_sz, size_eff;
  logic [1:0]  lane;
  logic        acc_err, accept;
  logic [AW-1:0] idx;
  logic [3:0]  bank_we;
  logic [31:0] bank_wdata, bank_rdata;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input mem_size_t sz,
                                              input logic [1:0] ln, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (ln)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: load_extend = {{24{~uns & b[7]}}, b};
      SZ_HALF: load_extend = {{16{~uns & h[15]}}, h};
      default: load_extend = w;
    endcase
  endfunction

  assign req_sz    = mem_size_t'(req_size);
  assign idx       = req_addr[AW+1:2];
  // Ready is gated by rst_n so it reads 0 while reset is held, 1 as soon as it releases.
  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

`ifdef DMEM_CTRL_CHECK_EN
  assign size_eff = req_sz;
  assign lane     = req_addr[1:0];
  assign acc_err  = (req_sz == SZ_HALF && req_addr[0])
                 || (req_sz == SZ_WORD && req_addr[1:0] != 2'b00)
                 || (req_sz == SZ_RSVD)
                 || ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  logic unused_addr_hi;
  assign size_eff = (req_sz == SZ_RSVD) ? SZ_WORD : req_sz;
  always_comb begin
    lane = 2'b00;
    if (size_eff == SZ_BYTE)      lane = req_addr[1:0];
    else if (size_eff == SZ_HALF) lane = {req_addr[1], 1'b0};
  end
  assign acc_err        = 1'b0;
  assign unused_addr_hi = ^req_addr[31:AW+2];
`endif

  assign bank_we = (accept && req_we && !acc_err) ? lane_mask(size_eff, lane) : 4'b0000;

  always_comb begin
    case (size_eff)
      SZ_BYTE: bank_wdata = {4{req_wdata[7:0]}};
      SZ_HALF: bank_wdata = {2{req_wdata[15:0]}};
      default: bank_wdata = req_wdata;
    endcase
  end

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk  (clk),
    .addr (idx),
    .we   (bank_we),
    .wdata(bank_wdata),
    .rdata(bank_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_we || acc_err || READ_LAT == 1) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            if (!req_we && !acc_err)
              rsp_rdata_d = load_extend(bank_rdata, size_eff, lane, req_unsigned);
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_extend(hold_word_q, hold_size_q, hold_lane_q, hold_uns_q);
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Load word is captured at accept so later stores cannot disturb an in-flight load.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_word_q <= bank_rdata;
      hold_size_q <= size_eff;
      hold_lane_q <= lane;
      hold_uns_q  <= req_unsigned;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
